// File: rtl/seg7_scan_driver_if.sv
// Bundle of load/brightness inputs and display outputs for seg7_scan_driver.
// SEG7_BLINK_EN adds BLINK_MASK to the bundle.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [8*NUM_DIGITS-1:0] DATA;
  logic [NUM_DIGITS-1:0]   RAW_MASK;
  logic [NUM_DIGITS-1:0]   DP_MASK;
  logic                    LOAD;
  logic [3:0]              BRIGHT;
  logic                    READY;
  logic                    FRAME_TICK;
  logic [7:0]              SEGMENT;
  logic [NUM_DIGITS-1:0]   DIG;
`ifdef SEG7_BLINK_EN
  logic [NUM_DIGITS-1:0]   BLINK_MASK;

  modport master (
    output DATA, RAW_MASK, DP_MASK, BLINK_MASK, LOAD, BRIGHT,
    input  READY, FRAME_TICK, SEGMENT, DIG
  );
  modport slave (
    input  DATA, RAW_MASK, DP_MASK, BLINK_MASK, LOAD, BRIGHT,
    output READY, FRAME_TICK, SEGMENT, DIG
  );
`else
  modport master (
    output DATA, RAW_MASK, DP_MASK, LOAD, BRIGHT,
    input  READY, FRAME_TICK, SEGMENT, DIG
  );
  modport slave (
    input  DATA, RAW_MASK, DP_MASK, LOAD, BRIGHT,
    output READY, FRAME_TICK, SEGMENT, DIG
  );
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: ASCII decode, double-buffered
// load, anti-ghost blanking, 16-level frame PWM. Optional blinking: SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1024,
  parameter int BLANK_CYC  = 16
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_LOG2 = 6
`endif
) (
  input logic               CLK,
  input logic               RST_N,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [8*NUM_DIGITS-1:0] SPACES = {NUM_DIGITS{8'h20}};

  logic [CNT_W-1:0]        cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [3:0]              phase_p0;
  logic [3:0]              bright_p0;
  logic [8*NUM_DIGITS-1:0] act_data, pend_data, sel_data;
  logic [NUM_DIGITS-1:0]   act_raw, pend_raw, sel_raw;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp, sel_dp;
  logic                    ready_q;
  logic                    frame_start, frame_last;
  logic                    blink_off, lit;
  logic [3:0]              bright_eff;
  logic [7:0]              cur_byte, pattern;
  logic [7:0]              seg_nxt, seg_p1;
  logic [NUM_DIGITS-1:0]   dig_nxt, dig_p1;

  function automatic logic [7:0] ascii_glyph(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      "0": ascii_glyph = 8'h3F;  "1": ascii_glyph = 8'h06;
      "2": ascii_glyph = 8'h5B;  "3": ascii_glyph = 8'h4F;
      "4": ascii_glyph = 8'h66;  "5": ascii_glyph = 8'h6D;
      "6": ascii_glyph = 8'h7D;  "7": ascii_glyph = 8'h07;
      "8": ascii_glyph = 8'h7F;  "9": ascii_glyph = 8'h6F;
      "A": ascii_glyph = 8'h77;  "B": ascii_glyph = 8'h7C;
      "C": ascii_glyph = 8'h39;  "D": ascii_glyph = 8'h5E;
      "E": ascii_glyph = 8'h79;  "F": ascii_glyph = 8'h71;
      "G": ascii_glyph = 8'h3D;  "H": ascii_glyph = 8'h76;
      "I": ascii_glyph = 8'h30;  "J": ascii_glyph = 8'h1E;
      "K": ascii_glyph = 8'h75;  "L": ascii_glyph = 8'h38;
      "M": ascii_glyph = 8'h55;  "N": ascii_glyph = 8'h54;
      "O": ascii_glyph = 8'h5C;  "P": ascii_glyph = 8'h73;
      "Q": ascii_glyph = 8'h67;  "R": ascii_glyph = 8'h50;
      "S": ascii_glyph = 8'h6D;  "T": ascii_glyph = 8'h78;
      "U": ascii_glyph = 8'h3E;  "V": ascii_glyph = 8'h1C;
      "W": ascii_glyph = 8'h6A;  "X": ascii_glyph = 8'h49;
      "Y": ascii_glyph = 8'h6E;  "Z": ascii_glyph = 8'h5B;
      "-": ascii_glyph = 8'h40;  "_": ascii_glyph = 8'h08;
      "=": ascii_glyph = 8'h48;  ".": ascii_glyph = 8'h80;
      default: ascii_glyph = 8'h00;
    endcase
  endfunction

  assign frame_start = (cnt_p0 == '0) && (idx_p0 == '0);
  assign frame_last  = (cnt_p0 == CNT_LAST) && (idx_p0 == IDX_LAST);

  // Stage p0: slot counter, digit index, PWM phase
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_p0   <= '0;
      idx_p0   <= '0;
      phase_p0 <= '0;
    end else begin
      if (cnt_p0 == CNT_LAST) begin
        cnt_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
      if (frame_last) phase_p0 <= phase_p0 + 4'd1;
    end
  end

  // Pending/active double buffer; a load coinciding with frame start stays pending
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_data <= SPACES;
      pend_raw  <= '0;
      pend_dp   <= '0;
      act_data  <= SPACES;
      act_raw   <= '0;
      act_dp    <= '0;
      bright_p0 <= '0;
      ready_q   <= 1'b1;
    end else begin
      if (frame_start) begin
        act_data  <= pend_data;
        act_raw   <= pend_raw;
        act_dp    <= pend_dp;
        bright_p0 <= bus.BRIGHT;
      end
      if (bus.LOAD) begin
        pend_data <= bus.DATA;
        pend_raw  <= bus.RAW_MASK;
        pend_dp   <= bus.DP_MASK;
        ready_q   <= 1'b0;
      end else if (frame_start) begin
        ready_q   <= 1'b1;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  logic [NUM_DIGITS-1:0] act_blink, pend_blink, sel_blink;
  logic [BLINK_LOG2:0]   frame_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_blink <= '0;
      act_blink  <= '0;
      frame_cnt  <= '0;
    end else begin
      if (frame_start) act_blink <= pend_blink;
      if (bus.LOAD) pend_blink <= bus.BLINK_MASK;
      if (frame_last) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign sel_blink = frame_start ? pend_blink : act_blink;
  assign blink_off = sel_blink[idx_p0] & frame_cnt[BLINK_LOG2];
`else
  assign blink_off = 1'b0;
`endif

  // Frame-start cycle reads the buffer being transferred so digit 0 shows new data at once
  assign sel_data   = frame_start ? pend_data : act_data;
  assign sel_raw    = frame_start ? pend_raw  : act_raw;
  assign sel_dp     = frame_start ? pend_dp   : act_dp;
  assign bright_eff = frame_start ? bus.BRIGHT : bright_p0;
  assign cur_byte   = sel_data[8*int'(idx_p0) +: 8];

  always_comb begin
    pattern = sel_raw[idx_p0] ? cur_byte : ascii_glyph(cur_byte);
    if (sel_dp[idx_p0]) pattern[7] = 1'b1;
    seg_nxt = ~pattern;
    lit = (cnt_p0 >= CNT_BLANK) && ((bright_eff == 4'hF) || (phase_p0 < bright_eff)) && !blink_off;
    dig_nxt = '1;
    if (lit) dig_nxt[idx_p0] = 1'b0;
  end

  // Stage p1: registered pin drive
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_p1 <= 8'hFF;
      dig_p1 <= '1;
    end else begin
      seg_p1 <= seg_nxt;
      dig_p1 <= dig_nxt;
    end
  end

  assign bus.SEGMENT    = seg_p1;
  assign bus.DIG        = dig_p1;
  assign bus.READY      = ready_q;
  assign bus.FRAME_TICK = frame_last;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 64-cycle slots, 4-cycle blank).
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int SD = 64;
  localparam int BC = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 CLK = ~CLK;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS(ND),
    .SCAN_DIV(SD),
    .BLANK_CYC(BC)
`ifdef SEG7_BLINK_EN
    , .BLINK_LOG2(1)
`endif
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  // cyc = number of rising edges since reset release; outputs show state cyc-1
  task automatic step;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_load(input logic [31:0] data, input logic [3:0] raw, input logic [3:0] dp);
    bus.DATA     = data;
    bus.RAW_MASK = raw;
    bus.DP_MASK  = dp;
    bus.LOAD     = 1'b1;
    step();
    bus.LOAD     = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (bus.SEGMENT !== 8'hFF) begin n_errors++; $display("FAIL rst_seg: got %h want ff", bus.SEGMENT); end
    n_checks++; if (bus.DIG !== 4'hF) begin n_errors++; $display("FAIL rst_dig: got %h want f", bus.DIG); end
    n_checks++; if (bus.READY !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b want 1", bus.READY); end
    n_checks++; if (bus.FRAME_TICK !== 1'b0) begin n_errors++; $display("FAIL rst_tick: got %b want 0", bus.FRAME_TICK); end
    do_load(32'h4241_3231, 4'b0000, 4'b0000);
    goto(2*SD + 30);
    n_checks++; if (bus.DIG !== 4'b1011) begin n_errors++; $display("FAIL mid_dig: got %b want 1011", bus.DIG); end
    n_checks++; if (bus.READY !== 1'b0) begin n_errors++; $display("FAIL mid_ready: got %b want 0", bus.READY); end
    RST_N = 1'b0;
    #1;
    n_checks++; if (bus.SEGMENT !== 8'hFF) begin n_errors++; $display("FAIL arst_seg: got %h want ff", bus.SEGMENT); end
    n_checks++; if (bus.DIG !== 4'hF) begin n_errors++; $display("FAIL arst_dig: got %h want f", bus.DIG); end
    n_checks++; if (bus.READY !== 1'b1) begin n_errors++; $display("FAIL arst_ready: got %b want 1", bus.READY); end
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc = 0;
    goto(BC);
    n_checks++; if (bus.DIG !== 4'hF) begin n_errors++; $display("FAIL restart_blank: got %b want 1111", bus.DIG); end
    step();
    n_checks++; if (bus.DIG !== 4'b1110) begin n_errors++; $display("FAIL restart_dig0: got %b want 1110", bus.DIG); end
    n_checks++; if (bus.SEGMENT !== 8'hFF) begin n_errors++; $display("FAIL restart_seg: got %h want ff", bus.SEGMENT); end
    goto(254);
    n_checks++; if (bus.FRAME_TICK !== 1'b0) begin n_errors++; $display("FAIL tick_early: got %b want 0", bus.FRAME_TICK); end
    step();
    n_checks++; if (bus.FRAME_TICK !== 1'b1) begin n_errors++; $display("FAIL tick_first: got %b want 1", bus.FRAME_TICK); end
  endtask

  task automatic test_decode;
    logic [7:0] exp_seg [4];
    int ticks, bad_pos;
    exp_seg[0] = 8'hF9; exp_seg[1] = 8'hA4; exp_seg[2] = 8'h88; exp_seg[3] = 8'h83;
    goto(300);
    do_load(32'h4241_3231, 4'b0000, 4'b0000);  // digit0..3 = '1','2','A','B'
    n_checks++; if (bus.READY !== 1'b0) begin n_errors++; $display("FAIL load_ready: got %b want 0", bus.READY); end
    goto(512);
    n_checks++; if (bus.READY !== 1'b0) begin n_errors++; $display("FAIL pend_ready: got %b want 0", bus.READY); end
    step();
    n_checks++; if (bus.READY !== 1'b1) begin n_errors++; $display("FAIL xfer_ready: got %b want 1", bus.READY); end
    for (int d = 0; d < ND; d++) begin
      goto(512 + SD*d + BC);
      n_checks++; if (bus.DIG !== 4'hF) begin n_errors++; $display("FAIL guard_dig%0d: got %b want 1111", d, bus.DIG); end
      n_checks++; if (bus.SEGMENT !== exp_seg[d]) begin n_errors++; $display("FAIL guard_seg%0d: got %h want %h", d, bus.SEGMENT, exp_seg[d]); end
      step();
      n_checks++; if (bus.DIG !== ~(4'b0001 << d)) begin n_errors++; $display("FAIL on_dig%0d: got %b want %b", d, bus.DIG, ~(4'b0001 << d)); end
      n_checks++; if (bus.SEGMENT !== exp_seg[d]) begin n_errors++; $display("FAIL on_seg%0d: got %h want %h", d, bus.SEGMENT, exp_seg[d]); end
      goto(512 + SD*d + SD);
      n_checks++; if (bus.DIG !== ~(4'b0001 << d)) begin n_errors++; $display("FAIL end_dig%0d: got %b want %b", d, bus.DIG, ~(4'b0001 << d)); end
    end
    ticks = 0;
    bad_pos = 0;
    repeat (512) begin
      step();
      if (bus.FRAME_TICK === 1'b1) begin
        ticks++;
        if (cyc % 256 != 255) bad_pos++;
      end
    end
    n_checks++; if (ticks !== 2) begin n_errors++; $display("FAIL tick_count: got %0d want 2", ticks); end
    n_checks++; if (bad_pos !== 0) begin n_errors++; $display("FAIL tick_pos: got %0d misplaced want 0", bad_pos); end
  endtask

  task automatic test_back_to_back;
    int bad, lit;
    goto(1300);
    do_load(32'h3131_3131, 4'b0000, 4'b0000);
    n_checks++; if (bus.READY !== 1'b0) begin n_errors++; $display("FAIL b2b_ready1: got %b want 0", bus.READY); end
    goto(1400);
    do_load(32'h3232_3232, 4'b0000, 4'b0000);
    goto(1536);
    n_checks++; if (bus.READY !== 1'b0) begin n_errors++; $display("FAIL b2b_ready2: got %b want 0", bus.READY); end
    bad = 0;
    lit = 0;
    while (cyc < 1792) begin
      step();
      if (cyc == 1537 && bus.READY !== 1'b1) bad++;
      if (bus.DIG !== 4'hF) begin
        lit++;
        if (bus.SEGMENT !== 8'hA4) bad++;
      end
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL b2b_shown: got %0d bad samples want 0", bad); end
    n_checks++; if (lit !== 240) begin n_errors++; $display("FAIL b2b_lit: got %0d want 240", lit); end
    // This load lands on the frame-start edge itself
    do_load(32'h3030_3030, 4'b0000, 4'b0000);
    n_checks++; if (bus.READY !== 1'b0) begin n_errors++; $display("FAIL coinc_ready: got %b want 0", bus.READY); end
    goto(1797);
    n_checks++; if (bus.SEGMENT !== 8'hA4) begin n_errors++; $display("FAIL coinc_old: got %h want a4", bus.SEGMENT); end
    goto(2053);
    n_checks++; if (bus.SEGMENT !== 8'hC0) begin n_errors++; $display("FAIL coinc_new: got %h want c0", bus.SEGMENT); end
    n_checks++; if (bus.READY !== 1'b1) begin n_errors++; $display("FAIL coinc_ready2: got %b want 1", bus.READY); end
  endtask

  task automatic test_raw_dp;
    logic [7:0] exp_seg [4];
    exp_seg[0] = 8'h24; exp_seg[1] = 8'hB6; exp_seg[2] = 8'hFF; exp_seg[3] = 8'hFF;
    goto(2100);
    do_load({8'h23, 8'h20, 8'h49, 8'h7A}, 4'b0010, 4'b0001);
    for (int d = 0; d < ND; d++) begin
      goto(2304 + SD*d + BC + 1);
      n_checks++; if (bus.SEGMENT !== exp_seg[d]) begin n_errors++; $display("FAIL raw_seg%0d: got %h want %h", d, bus.SEGMENT, exp_seg[d]); end
      n_checks++; if (bus.DIG !== ~(4'b0001 << d)) begin n_errors++; $display("FAIL raw_dig%0d: got %b want %b", d, bus.DIG, ~(4'b0001 << d)); end
    end
  endtask

  task automatic test_brightness;
    int lit_cnt [4];
    int bad;
    for (int d = 0; d < ND; d++) lit_cnt[d] = 0;
    goto(2600);
    bus.BRIGHT = 4'd4;
    // Frame 10 runs with latched 15 although phase 10 >= 4
    goto(2700);
    n_checks++; if (bus.DIG !== 4'b1011) begin n_errors++; $display("FAIL bright_latch: got %b want 1011", bus.DIG); end
    for (int f = 0; f < 32; f++) begin
      for (int d = 0; d < ND; d++) begin
        goto(2816 + 256*f + SD*d + 11);
        if (bus.DIG[d] === 1'b0) lit_cnt[d]++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      n_checks++; if (lit_cnt[d] !== 8) begin n_errors++; $display("FAIL pwm_frames%0d: got %0d want 8", d, lit_cnt[d]); end
    end
    bus.BRIGHT = 4'd0;
    goto(11008);
    bad = 0;
    repeat (256) begin
      step();
      if (bus.DIG !== 4'hF) bad++;
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL bright0_dark: got %0d lit samples want 0", bad); end
  endtask

`ifdef SEG7_BLINK_EN
  task automatic test_blink;
    logic exp_dark;
    goto(11300);
    bus.BRIGHT = 4'hF;
    bus.BLINK_MASK = 4'b0100;
    do_load(32'h3838_3838, 4'b0000, 4'b0000);
    bus.BLINK_MASK = 4'b0000;
    for (int k = 45; k < 53; k++) begin
      exp_dark = ((k % 4) >= 2);
      goto(256*k + 11);
      n_checks++; if (bus.DIG !== 4'b1110) begin n_errors++; $display("FAIL blink_d0_f%0d: got %b want 1110", k, bus.DIG); end
      goto(256*k + 2*SD + 11);
      n_checks++; if (bus.DIG !== (exp_dark ? 4'b1111 : 4'b1011)) begin n_errors++; $display("FAIL blink_d2_f%0d: got %b want %b", k, bus.DIG, exp_dark ? 4'b1111 : 4'b1011); end
    end
  endtask
`endif

  initial begin
    bus.DATA     = '0;
    bus.RAW_MASK = '0;
    bus.DP_MASK  = '0;
    bus.LOAD     = 1'b0;
    bus.BRIGHT   = 4'hF;
`ifdef SEG7_BLINK_EN
    bus.BLINK_MASK = '0;
`endif
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_raw_dp();
    test_brightness();
`ifdef SEG7_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
